syrup_mem1p_responder: RTL and testbench
========================================

// Module: syrup_mem1p_responder
//
// PURPOSE
// Memory-side responder for the single-port Syrup request interface (ADDR/D/WE/RE/BE -> Q).
// It serves the word-addressed requests that user logic issues through a single-port memory
// port, and is backed by an on-chip word array.
// It performs a post-reset clear sweep, has a fixed read-latency pipeline and flags
// out-of-range accesses.
// It is used as the backing store for simulation and for on-FPGA bring-up of user logic.
//
// PARAMETERS
// ADDR_WIDTH     24  byte-address width of ADDR
// DATA_WIDTH     32  word width; must be a multiple of 8, with DATA_WIDTH/8 a power of 2
// MEM_DEPTH_LOG  10  log2 of array depth in words
// READ_LATENCY   2   cycles from RE sample to QVALID; legal range 1..4
// INIT_CLEAR     1   1 = zero the whole array after reset; 0 = skip the sweep
//
// PORTS
// CLK     in   1               clock
// RST     in   1               synchronous reset, active-high
// ADDR    in   ADDR_WIDTH      byte address; low log2(DATA_WIDTH/8) bits ignored
// D       in   DATA_WIDTH      write data
// WE      in   1               write request, sampled every cycle
// RE      in   1               read request, sampled every cycle
// BE      in   DATA_WIDTH/8    byte enables (used only under the macro, see CONFIGURATION)
// Q       out  DATA_WIDTH      read data; holds the last returned value
// QVALID  out  1               1-cycle pulse when Q carries a new read result
// READY   out  1               1 = requests are accepted; 0 during the clear sweep
// ERR     out  1               1-cycle pulse, aligned with QVALID, for an out-of-range read
//
// BEHAVIOUR
// - Reset values: Q=0, QVALID=0, READY=0, ERR=0. The read pipeline is flushed.
//   A reset asserted mid-operation drops in-flight reads (no QVALID for them) and restarts the FSM.
// - FSM states: RST -> CLEAR (INIT_CLEAR=1) or RST -> RUN (INIT_CLEAR=0).
//   With INIT_CLEAR=0, READY rises 1 cycle after RST deasserts.
// - CLEAR: a counter cnt runs 0..2^MEM_DEPTH_LOG-1 and writes 0 to mem[cnt], one word per cycle.
//   At the last word the FSM goes to RUN. READY=1 starting on the cycle after the last write.
//   With depth 1024, READY rises exactly 1024 cycles after RST deasserts.
// - Requests with READY=0 are ignored: no write, no QVALID, no ERR.
// - Word index widx = ADDR >> log2(DATA_WIDTH/8). In range iff widx < 2^MEM_DEPTH_LOG.
// - Write (READY & WE, in range): mem[widx] <= D on the same edge. Out-of-range writes are
//   silently dropped (no ERR).
// - Read (READY & RE), sampled at edge N: Q and QVALID are presented at edge N+READY_LATENCY,
//   i.e. edge N+READ_LATENCY. One result is accepted per cycle; back-to-back reads give
//   back-to-back QVALID pulses in order.
// - Out-of-range read: Q=0, QVALID=1 and ERR=1 in the same cycle.
// - WE & RE in the same cycle, same address: read-before-write. The read returns the old word;
//   the write still commits.
// - Address wrap: ADDR is not incremented internally. The user's ADDR rollover at 2^ADDR_WIDTH
//   is handled purely by the range check.
// - Q holds its value when QVALID=0. Q is never X after reset.
//
// CONFIGURATION
// SYRUP_BYTE_ENABLE_EN
// - Defined: on a write, byte i of mem[widx] is updated only if BE[i]=1.
//   BE=0 with WE=1 writes nothing.
// - Undefined: BE is ignored; every write updates the full word. The BE port stays present
//   so connections are unchanged.
//
// TESTING
// 1. Post-reset sweep, INIT_CLEAR=1, depth 1024: pulse RST, then hold RE=1 at ADDR=0
//    -> READY=0 and no QVALID for 1024 cycles; then READY=1; the first QVALID arrives
//    READ_LATENCY cycles after READY, with Q=0.
// 2. Streaming read: write 0xA5A5_0000+i to ADDR=4*i for i=0..15, then RE=1 with ADDR
//    stepping by 4 each cycle -> 16 consecutive QVALID pulses with Q=0xA5A5_0000..0xA5A5_000F,
//    first pulse at a lag of READ_LATENCY.
// 3. Read-before-write: mem[3]=0x1111_1111; in one cycle ADDR=12, WE=1, RE=1, D=0x2222_2222
//    -> the read returns 0x1111_1111; the next read returns 0x2222_2222.
// 4. Out of range: ADDR=4*1024 with RE=1 -> QVALID=1, ERR=1, Q=0.
//    A WE at that address leaves mem[0] unchanged.
// 5. Byte enables (macro defined): mem[0]=0x0000_0000; write D=0xDDCC_BBAA with BE=4'b0101
//    -> reading back gives 0x00CC_00AA. Macro undefined: reading back gives 0xDDCC_BBAA.
// 6. Reset mid-flight: issue RE at edge N; assert RST at edge N+1 -> no QVALID is ever
//    produced for that read; Q=0; READY=0 until the sweep completes again.

Source files
------------

// File: rtl/syrup_mem1p_responder.sv
// Single-port Syrup memory responder: word array with post-reset clear sweep, fixed read latency
// and out-of-range flagging. Define SYRUP_BYTE_ENABLE_EN to honour BE on writes.
module syrup_mem1p_responder #(
    parameter int ADDR_WIDTH    = 24,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_DEPTH_LOG = 10,
    parameter int READ_LATENCY  = 2,
    parameter int INIT_CLEAR    = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [ADDR_WIDTH-1:0]   ADDR,
    input  logic [DATA_WIDTH-1:0]   D,
    input  logic                    WE,
    input  logic                    RE,
    input  logic [DATA_WIDTH/8-1:0] BE,
    output logic [DATA_WIDTH-1:0]   Q,
    output logic                    QVALID,
    output logic                    READY,
    output logic                    ERR
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(NB);
    localparam int DEPTH = 1 << MEM_DEPTH_LOG;
    localparam int L     = READ_LATENCY;
    localparam logic [MEM_DEPTH_LOG-1:0] LAST    = MEM_DEPTH_LOG'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]      DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {S_RST, S_CLEAR, S_RUN} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                 state_q, state_d;
    logic [MEM_DEPTH_LOG-1:0] cnt_q, cnt_d;
    logic                   ready_q, ready_d;
    logic [L-1:0]           valid_q, valid_d;
    logic [L-1:0]           err_q, err_d;
    logic [DATA_WIDTH-1:0]  data_q [L];
    logic [DATA_WIDTH-1:0]  data_d [L];

    logic [ADDR_WIDTH-1:0]    widx_full;
    logic [MEM_DEPTH_LOG-1:0] widx;
    logic                     in_range;
    logic                     req_ok, rd_fire, clr_we, mem_we;
    logic [MEM_DEPTH_LOG-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic [NB-1:0]            mem_wbe;
    logic [NB-1:0]            user_be;

    assign widx_full = ADDR >> OFF;
    assign widx      = widx_full[MEM_DEPTH_LOG-1:0];
    assign in_range  = {1'b0, widx_full} < DEPTH_W;
    assign req_ok    = ready_q & ~RST;
    assign rd_fire   = req_ok & RE;

`ifdef SYRUP_BYTE_ENABLE_EN
    assign user_be = BE;
`else
    logic be_unused;
    assign be_unused = ^BE;
    assign user_be   = '1;
`endif

    // Sweep starts directly out of reset so the last word lands 2^MEM_DEPTH_LOG edges later.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        clr_we  = 1'b0;
        case (state_q)
            S_RST, S_CLEAR: begin
                if (INIT_CLEAR != 0) begin
                    clr_we = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = S_RUN;
                        ready_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + MEM_DEPTH_LOG'(1);
                        state_d = S_CLEAR;
                    end
                end else begin
                    state_d = S_RUN;
                    ready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_we    = ~RST & (clr_we | (req_ok & WE & in_range));
        mem_waddr = clr_we ? cnt_q : widx;
        mem_wdata = clr_we ? '0 : D;
        mem_wbe   = clr_we ? '1 : user_be;
    end

    always_comb begin
        valid_d[0] = rd_fire;
        err_d[0]   = rd_fire & ~in_range;
        data_d[0]  = data_q[0];
        for (int k = 1; k < L; k++) begin
            valid_d[k] = valid_q[k-1];
            err_d[k]   = err_q[k-1];
            data_d[k]  = valid_q[k-1] ? data_q[k-1] : data_q[k];
        end
    end

    always_ff @(posedge CLK) begin
        for (int b = 0; b < NB; b++) begin
            if (mem_we && mem_wbe[b]) begin
                mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // Stage 0 is the registered array read; the same-edge write is not visible to it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_RST;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= '0;
            err_q   <= '0;
            for (int k = 0; k < L; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            data_q[0] <= rd_fire ? (in_range ? mem[widx] : '0) : data_d[0];
            for (int k = 1; k < L; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign Q      = data_q[L-1];
    assign QVALID = valid_q[L-1];
    assign ERR    = err_q[L-1];
    assign READY  = ready_q;
endmodule

// File: tb/tb_syrup_mem1p_responder.sv
// Scoreboard bench for syrup_mem1p_responder: reference word array plus expected-result queue.
module tb_syrup_mem1p_responder;
    localparam int AW = 24, DW = 32, DL = 10, L = 2, IC = 1;
    localparam int DEPTH = 1 << DL;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [AW-1:0] ADDR = '0;
    logic [DW-1:0] D = '0;
    logic          WE = 1'b0, RE = 1'b0;
    logic [3:0]    BE = '0;
    logic [DW-1:0] Q;
    logic          QVALID, READY, ERR;

    syrup_mem1p_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH_LOG(DL),
        .READ_LATENCY(L), .INIT_CLEAR(IC)
    ) dut (
        .CLK(CLK), .RST(RST), .ADDR(ADDR), .D(D), .WE(WE), .RE(RE), .BE(BE),
        .Q(Q), .QVALID(QVALID), .READY(READY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            at;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [DW-1:0] model [DEPTH];
    int            total = 0;
    int            bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference behaviour of the request currently on the pins, applied if it will be accepted.
    task automatic accept();
        int unsigned wi;
        bit          inr;
        logic [3:0]  be_eff;
        exp_t        e;
        if (READY === 1'b1 && RST === 1'b0) begin
            wi  = int'(ADDR >> 2);
            inr = wi < DEPTH;
            if (RE) begin
                e.data = inr ? model[wi] : '0;
                e.err  = !inr;
                e.at   = cyc + L;
                sb.push_back(e);
            end
`ifdef SYRUP_BYTE_ENABLE_EN
            be_eff = BE;
`else
            be_eff = 4'hF;
`endif
            if (WE && inr) begin
                for (int b = 0; b < 4; b++)
                    if (be_eff[b]) model[wi][8*b +: 8] = D[8*b +: 8];
            end
        end
    endtask

    task automatic step(input logic we, input logic re, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [3:0] be);
        @(posedge CLK);
        #1;
        WE = we; RE = re; ADDR = a; D = d; BE = be;
        accept();
    endtask

    task automatic drain();
        int n = 0;
        @(posedge CLK); #1;
        WE = 1'b0; RE = 1'b0;
        while (sb.size() > 0 && n < 50) begin
            @(posedge CLK);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic do_reset(input logic hold_re);
        int n = 0;
        @(posedge CLK); #1;
        RST = 1'b1; WE = 1'b0; RE = 1'b0;
        sb.delete();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_q", Q, 0);
        chk("rst_qvalid", 32'(QVALID), 0);
        chk("rst_ready", 32'(READY), 0);
        chk("rst_err", 32'(ERR), 0);
        if (IC != 0) foreach (model[i]) model[i] = '0;
        RE = hold_re; ADDR = '0; RST = 1'b0;
        while (READY !== 1'b1 && n < 3000) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("ready_delay", n, (IC != 0) ? DEPTH : 1);
        accept();
    endtask

    always @(negedge CLK) begin
        if (QVALID === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_qvalid: got q=%h err=%b want no result", Q, ERR);
            end else begin
                mon_e = sb.pop_front();
                if (Q !== mon_e.data || ERR !== mon_e.err || cyc != mon_e.at) begin
                    bad++;
                    $display("FAIL read_result: got q=%h err=%b cyc=%0d want q=%h err=%b cyc=%0d",
                             Q, ERR, cyc, mon_e.data, mon_e.err, mon_e.at);
                end else begin
                    $display("read q=%h err=%b cyc=%0d ok", Q, ERR, cyc);
                end
            end
        end else if (ERR === 1'b1) begin
            total++;
            bad++;
            $display("FAIL err_without_qvalid: got err=1 want err=0");
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (model[i]) model[i] = '0;
        // Sweep with a read held on ADDR 0 the whole time.
        do_reset(1'b1);
        step(1'b0, 1'b0, '0, '0, 4'h0);

        // Streaming write then back-to-back reads.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, AW'(4*i), 32'hA5A5_0000 + DW'(i), 4'hF);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, AW'(4*i), '0, 4'h0);

        // Read-before-write on one word.
        step(1'b1, 1'b0, 24'd12, 32'h1111_1111, 4'hF);
        step(1'b1, 1'b1, 24'd12, 32'h2222_2222, 4'hF);
        step(1'b0, 1'b1, 24'd12, '0, 4'h0);

        // Out of range read/write, and the top of the byte address space.
        step(1'b0, 1'b1, AW'(4*DEPTH), '0, 4'h0);
        step(1'b1, 1'b0, AW'(4*DEPTH), 32'hDEAD_BEEF, 4'hF);
        step(1'b0, 1'b1, 24'd0, '0, 4'h0);
        step(1'b0, 1'b1, 24'hFF_FFFC, '0, 4'h0);

        // Byte-enable write.
        step(1'b1, 1'b0, 24'd0, 32'h0000_0000, 4'hF);
        step(1'b1, 1'b0, 24'd0, 32'hDDCC_BBAA, 4'b0101);
        step(1'b0, 1'b1, 24'd0, '0, 4'h0);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            logic [AW-1:0] a;
            int sel = $urandom_range(0, 7);
            if (sel == 0)      a = AW'($urandom);
            else if (sel == 1) a = AW'(4*DEPTH + 4*$urandom_range(0, 15));
            else               a = AW'(4*$urandom_range(0, 31) + $urandom_range(0, 3));
            step(1'($urandom), 1'($urandom), a, $urandom, 4'($urandom));
        end
        drain();

        // Read in flight when reset hits: it must never return.
        step(1'b0, 1'b1, 24'd4, '0, 4'h0);
        do_reset(1'b0);
        chk("q_after_midflight_reset", Q, 0);
        step(1'b0, 1'b1, 24'd4, '0, 4'h0);
        step(1'b0, 1'b1, 24'd8, '0, 4'h0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
